// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control block.
//   state_t     : controller FSM states
//   ctrl_t      : bundle of the per-cycle pipeline control outputs
//   CTRL_*      : the fixed control patterns, one per pipeline action
//   NOP_INSTR   : instruction word the datapath loads when a *_nop is asserted
//   DRAIN_DEPTH : cycles needed to flush F/D, D/X and X/M after a HALT
//   CNT_W       : width of the performance counters
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_DRAIN    = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam logic [15:0] NOP_INSTR   = 16'h0800;
    localparam int          DRAIN_DEPTH = 3;
    localparam int          CNT_W       = 16;

    typedef struct packed {
        logic pc_we;
        logic fd_we;
        logic dx_we;
        logic xm_we;
        logic pc_sel;
        logic fd_nop;
        logic dx_nop;
        logic mw_nop;
    } ctrl_t;

    // Bit order: pc_we fd_we dx_we xm_we | pc_sel fd_nop dx_nop mw_nop
    localparam ctrl_t CTRL_NORMAL = ctrl_t'(8'b1111_0000);
    localparam ctrl_t CTRL_RESET  = ctrl_t'(8'b0000_0111);
    localparam ctrl_t CTRL_HALT   = ctrl_t'(8'b0000_0000);
    localparam ctrl_t CTRL_MEM    = ctrl_t'(8'b0000_0001);
    localparam ctrl_t CTRL_BRANCH = ctrl_t'(8'b1111_1110);
    localparam ctrl_t CTRL_HAZ    = ctrl_t'(8'b0011_0010);
    localparam ctrl_t CTRL_IMEM   = ctrl_t'(8'b0111_0100);
    // A drain cycle bubbles fetch exactly like an instruction-memory stall.
    localparam ctrl_t CTRL_DRAIN  = ctrl_t'(8'b0111_0100);

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk     : clock
//   i_clr_n : synchronous active-low clear
//   i_inc   : count enable; the count sticks at all-ones instead of wrapping
//   o_cnt   : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         i_clr_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/halt controller for a 4-stage-register in-order core.
// Drives load enables and NOP-insert controls only; no datapath muxing here.
//   clk, rst_n              : clock, synchronous active-low reset
//   haz_stall, br_taken_x   : RAW hazard in decode, branch redirect from X
//   imem_stall, dmem_stall  : fetch not ready, data memory busy
//   halt_d                  : HALT valid in decode
//   pc_we..xm_we            : register load enables
//   pc_sel                  : 1 = branch target, 0 = PC+2
//   fd_nop, dx_nop, mw_nop  : load NOP instead of upstream data
//   halted                  : pipeline stopped after HALT retired
//   stall_cnt, flush_cnt    : saturating performance counters
//
// state      | meaning
// S_RUN      | normal issue, priorities evaluated each cycle
// S_MEM_WAIT | frozen behind a data-memory stall
// S_DRAIN    | HALT seen, bubbling fetch until older instructions retire
// S_HALT     | stopped until reset
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             haz_stall,
    input  logic             br_taken_x,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             halt_d,
    output logic             pc_we,
    output logic             fd_we,
    output logic             dx_we,
    output logic             xm_we,
    output logic             pc_sel,
    output logic             fd_nop,
    output logic             dx_nop,
    output logic             mw_nop,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     r_state;
    logic [1:0] r_drain_cnt;
    logic       r_halted;

    state_t     w_next_state;
    logic [1:0] w_next_cnt;
    ctrl_t      w_ctrl;
    logic       w_flush_inc;
    logic       w_stall_inc;

    always_comb begin
        w_ctrl       = CTRL_HALT;
        w_next_state = r_state;
        w_next_cnt   = r_drain_cnt;
        w_flush_inc  = 1'b0;
        if (!rst_n) begin
            w_ctrl = CTRL_RESET;
        end else if (r_state != S_HALT) begin
            if (dmem_stall) begin
                // A memory stall during drain keeps draining state, count frozen.
                w_ctrl = CTRL_MEM;
                if (r_state != S_DRAIN) begin
                    w_next_state = S_MEM_WAIT;
                end
            end else if (br_taken_x) begin
                // Redirect also cancels a drain: that HALT was wrong-path.
                w_ctrl       = CTRL_BRANCH;
                w_next_state = S_RUN;
                w_next_cnt   = '0;
                w_flush_inc  = 1'b1;
            end else if (haz_stall) begin
                w_ctrl = CTRL_HAZ;
                if (r_state == S_MEM_WAIT) begin
                    w_next_state = S_RUN;
                end
            end else if (r_state == S_DRAIN) begin
                w_ctrl     = CTRL_DRAIN;
                w_next_cnt = r_drain_cnt - 2'd1;
                if (r_drain_cnt <= 2'd1) begin
                    w_next_state = S_HALT;
                    w_next_cnt   = '0;
                end
            end else if (imem_stall) begin
                w_ctrl       = CTRL_IMEM;
                w_next_state = S_RUN;
            end else begin
                w_ctrl       = CTRL_NORMAL;
                w_next_state = S_RUN;
                if (halt_d) begin
                    w_next_state = S_DRAIN;
                    w_next_cnt   = 2'(DRAIN_DEPTH);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_cnt;
            r_halted    <= (w_next_state == S_HALT);
        end
    end

    assign w_stall_inc = (r_state != S_HALT) && !w_ctrl.pc_we;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .i_clr_n (rst_n),
        .i_inc   (w_stall_inc),
        .o_cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .i_clr_n (rst_n),
        .i_inc   (w_flush_inc),
        .o_cnt   (flush_cnt)
    );

    assign pc_we  = w_ctrl.pc_we;
    assign fd_we  = w_ctrl.fd_we;
    assign dx_we  = w_ctrl.dx_we;
    assign xm_we  = w_ctrl.xm_we;
    assign pc_sel = w_ctrl.pc_sel;
    assign fd_nop = w_ctrl.fd_nop;
    assign dx_nop = w_ctrl.dx_nop;
    assign mw_nop = w_ctrl.mw_nop;
    assign halted = r_halted;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have port haz_stall, input, 1 bit: RAW hazard on the decode instruction, from the hazard detector.
REQ-004 The block SHALL have port br_taken_x, input, 1 bit: branch or jump in X resolved as a redirect.
REQ-005 The block SHALL have port imem_stall, input, 1 bit: fetch data not ready this cycle.
REQ-006 The block SHALL have port dmem_stall, input, 1 bit: data memory busy for the M-stage access.
REQ-007 The block SHALL have port halt_d, input, 1 bit: HALT instruction valid in decode.
REQ-008 The block SHALL have outputs pc_we, fd_we, dx_we and xm_we, each 1 bit: load enables for PC, F/D, D/X and X/M.
REQ-009 The block SHALL have output pc_sel, 1 bit: 1 = PC loads the branch target, 0 = PC+2.
REQ-010 The block SHALL have outputs fd_nop, dx_nop and mw_nop, each 1 bit: load NOP 16'h0800 into that register instead of upstream data.
REQ-011 The block SHALL have output halted, 1 bit: the pipeline is stopped after HALT retires.
REQ-012 The block SHALL have outputs stall_cnt and flush_cnt, each 16 bits: performance counters.

Function
REQ-013 The block SHALL implement FSM states RUN, MEM_WAIT, DRAIN and HALT.
REQ-014 In RUN and DRAIN, the block SHALL apply at most one action per cycle, in priority order: dmem_stall > br_taken_x > haz_stall > imem_stall > halt_d > normal.
REQ-015 dmem_stall SHALL set pc_we, fd_we, dx_we and xm_we to 0 and mw_nop to 1; next state SHALL be MEM_WAIT, or stay in DRAIN with the drain count frozen.
REQ-016 MEM_WAIT SHALL hold the REQ-015 outputs while dmem_stall is 1; on the first cycle dmem_stall is 0, it SHALL evaluate the RUN priorities and move to RUN.
REQ-017 br_taken_x SHALL give pc_we=1, pc_sel=1, fd_nop=1, dx_nop=1 and xm_we=1, and SHALL increment flush_cnt; it overrides haz_stall and imem_stall in the same cycle.
REQ-018 haz_stall SHALL give pc_we=0, fd_we=0 and dx_nop=1, with xm_we=1.
REQ-019 imem_stall SHALL give pc_we=0 and fd_nop=1, with dx_we=1 and xm_we=1.
REQ-020 halt_d in RUN with no higher-priority event SHALL give a normal advance and enter DRAIN with count 3.
REQ-021 Each advancing DRAIN cycle SHALL give pc_we=0, fd_nop=1, all other stages advancing, and SHALL decrement the count; at count 0 the next state SHALL be HALT.
REQ-022 br_taken_x in DRAIN SHALL cancel the drain (the HALT was wrong-path), apply REQ-017 and return to RUN.
REQ-023 HALT SHALL hold all *_we at 0, all *_nop at 0 and halted at 1 until reset; all inputs are ignored in HALT.
REQ-024 The normal action SHALL be all *_we at 1, pc_sel 0 and all *_nop at 0.
REQ-025 stall_cnt SHALL increment every cycle pc_we=0 in RUN, MEM_WAIT or DRAIN.
REQ-026 stall_cnt and flush_cnt SHALL saturate at 16'hFFFF, with no wrap.
REQ-027 All outputs except the counters and halted SHALL be combinational from state and inputs, with zero-cycle latency; state, drain count and counters SHALL be registered.

Reset
REQ-028 When rst_n is 0 at a clock edge, the block SHALL enter RUN with drain count 0, stall_cnt 0, flush_cnt 0 and halted 0.
REQ-029 While rst_n is 0, the block SHALL drive all *_we to 0, pc_sel to 0 and fd_nop, dx_nop and mw_nop to 1.
REQ-030 Reset SHALL take effect mid-MEM_WAIT, mid-DRAIN or in HALT with no residual state.

Structure
REQ-031 A shared package SHALL hold the state enum, the NOP_INSTR constant 16'h0800, the drain depth constant 3 and the counter width 16.
REQ-032 One sub-module, sat_counter (width parameter, inc input, sync active-low clear), SHALL be instantiated twice, once for each counter.
REQ-033 The block SHALL contain no datapath muxing; it drives controls only.

Verification
REQ-034 The bench SHALL cover: reset, then idle inputs for 5 cycles -> all *_we=1, stall_cnt=0, flush_cnt=0.
REQ-035 The bench SHALL cover: haz_stall=1 for 2 cycles -> pc_we=0, fd_we=0, dx_nop=1 for those 2 cycles, stall_cnt=2.
REQ-036 The bench SHALL cover: br_taken_x=1 together with haz_stall=1 and imem_stall=1 -> pc_sel=1, fd_nop=1, dx_nop=1, pc_we=1, flush_cnt=1.
REQ-037 The bench SHALL cover: dmem_stall=1 for 4 cycles with br_taken_x=1 throughout -> MEM_WAIT for 4 cycles, mw_nop=1, then the redirect on the 5th cycle, flush_cnt=1.
REQ-038 The bench SHALL cover: halt_d=1 -> 3 DRAIN cycles with fd_nop=1, then halted=1; a second run with br_taken_x on DRAIN cycle 2 -> back in RUN, halted stays 0.
REQ-039 The bench SHALL cover: stall_cnt preloaded near saturation by 65540 stall cycles -> stall_cnt=16'hFFFF and holds; then rst_n=0 for one cycle -> stall_cnt=0 and RUN.
